matmul_sequencer: RTL and testbench
===================================

# matmul_sequencer

Control sequencer for the 32×32 matrix-multiply datapath, which computes C = A·B from register arrays A, B and C and one multiply-accumulate unit. It accepts a job with run-time dimensions and walks the A/B read addresses in row-major, inner-index order. It issues MAC clear/enable and C write strobes, aligned to the array read latency. After computation it serves host-paced element readout of C through a `sample_load` / `sample` handshake.

## Interface
- `DIM_MAX`, 32: largest legal dimension.
- `IDX_W`, 5: index width, clog2(`DIM_MAX`).
- `DIM_W`, 6: dimension width; holds 1..`DIM_MAX`.
- `RD_LAT`, 1: array read latency in cycles, 1..3.

Ports:
- `clock`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: job request; accepted only when `busy`=0.
- `rows_a`, `inner`, `cols_b`  in  `DIM_W` each: dimensions M, N, P; sampled on an accepted `start`.
- `busy`  out  1: job in compute or drain.
- `done`  out  1: level; results in C are valid.
- `error`  out  1: one-cycle pulse for an illegal dimension.
- `rd_en`  out  1: A/B read strobe.
- `a_row`, `a_col`, `b_row`, `b_col`  out  `IDX_W` each: read indices.
- `mac_clear`, `mac_en`  out  1 each: MAC control, read-aligned.
- `c_we`  out  1: C write strobe.
- `c_row`, `c_col`  out  `IDX_W` each: C write index.
- `sample_load`  in  1: readout request.
- `rc_en`  out  1: C read strobe.
- `rc_row`, `rc_col`  out  `IDX_W` each: C read index.
- `sample`  out  1: C read data valid.
- `resulting_size`  out  2·`DIM_W`: {M, P} of the last accepted job.

## Operation
States:
- IDLE: `start` with M, N, P all in 1..32 → COMPUTE, dimensions latched, counters i=j=k=0.
  - Any dimension 0 or >32 → `error` pulse; stay IDLE; latched dimensions unchanged.
- COMPUTE: one `rd_en` every cycle, no bubbles.
  - Indices: a=(i,k), b=(k,j).
  - Counter order: k innermost, then j, then i; each wraps to 0 at its dimension−1.
  - After the read at (M−1, P−1, N−1) → DRAIN.
- DRAIN: no reads; wait for the final `c_we`, then → READOUT with `done`=1.
- READOUT: each cycle with `sample_load`=1 gives one `rc_en` at the current (rr, rc), then advances row-major over M×P.
  - The index wraps to (0,0) after (M−1, P−1), so C can be re-read.
  - `start` is accepted here, as in IDLE; `done` clears on acceptance.
- Pipeline, per read: `mac_en` and `mac_clear` (clear when k==0) follow `rd_en` by exactly `RD_LAT` cycles.
- `c_we`, with (i,j), follows the k==N−1 read by `RD_LAT`+1 cycles.

Boundary behaviour:
- `start` while `busy`=1: ignored, with no `error`.
- `start` and `sample_load` in the same cycle in READOUT: `start` wins and `sample_load` is dropped. Samples already in flight still emit `sample`.
- N=1: `mac_clear` and `mac_en` coincide on every product, and `c_we` follows each read.
- `reset` mid-job: next cycle every output is 0, state is IDLE, and the pipeline is flushed. No late `c_we` or `sample` appears.

## Timing
- Reset value of every output is 0, including `resulting_size`.
- For a `start` accepted at cycle 0:
  - `rd_en` is high over cycles 1..M·N·P.
  - The last `c_we` is at M·N·P+`RD_LAT`+1.
  - `done` is high from M·N·P+`RD_LAT`+2.
- `busy` is high from cycle 1 until the cycle before `done`.
- `sample` follows `rc_en` by `RD_LAT` cycles, and `rc_en` is combinational on `sample_load` in READOUT.
- Throughput is one product per cycle and one readout element per cycle.

## Structure
- Package `matmul_pkg` holds `DIM_MAX`, `IDX_W`, `DIM_W` and the state enum (IDLE, COMPUTE, DRAIN, READOUT).
- Sub-module `mm_index_counter`: a three-level nested counter with per-level limits, advance enable, and wrap/last flags.
  - Instantiated once for (i,j,k).
  - Its two-level form is reused for the readout index.
- The `RD_LAT` alignment is a shift register inline in the top module.

## Test plan
- M=N=P=1, `start` at cycle 0 with `RD_LAT`=1 → `rd_en` at 1; `mac_clear`+`mac_en` at 2; `c_we` (0,0) at 3; `done` at 4.
- M=2, N=3, P=2 → 12 contiguous `rd_en`; 4 `c_we` in order (0,0), (0,1), (1,0), (1,1); `done` at 15; `resulting_size`={2,2}.
- `start` with `inner`=0, then with `cols_b`=33 → one `error` pulse each; `busy` stays 0; `resulting_size` unchanged.
- After the 2×3×2 job, 5 `sample_load` pulses → `rc` indices (0,0), (0,1), (1,0), (1,1), (0,0) (wrap); 5 `sample` pulses, each `RD_LAT` later.
- `start` while `busy` → ignored. Then assert `reset` mid-COMPUTE → all outputs 0 next cycle; no `c_we` afterwards; a fresh job runs normally.
- In READOUT, `start` coincident with `sample_load` → new job accepted, `rc_en`=0 that cycle, the prior in-flight `sample` still emitted.

Source files
------------

// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matmul_pkg
// Brief    : Shared sizes, state encoding and pipeline tag for the matmul
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    localparam int DIM_MAX = 32;
    localparam int IDX_W   = $clog2(DIM_MAX);
    localparam int DIM_W   = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2,
        READOUT = 2'd3
    } state_t;

    // Travels alongside each A/B read until the array data comes back.
    typedef struct packed {
        logic             valid;
        logic             clear;
        logic             acc_last;
        logic             fin;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } rd_tag_t;

    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != '0) && (d <= DIM_W'(DIM_MAX));
    endfunction

    function automatic logic [IDX_W-1:0] dim_last(input logic [DIM_W-1:0] d);
        return IDX_W'(d - DIM_W'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mm_index_counter.sv
`default_nettype none
// ============================================================================
// Module   : mm_index_counter
// Brief    : Nested index counter; level 0 is innermost, each level wraps to
//            zero at its own limit and carries into the next.
// Revision : 1.0 - initial release
// ============================================================================
module mm_index_counter
    import matmul_pkg::*;
#(
    parameter int LEVELS = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         advance,
    input  logic [LEVELS-1:0][IDX_W-1:0] limit,
    output logic [LEVELS-1:0][IDX_W-1:0] idx,
    output logic [LEVELS-1:0]            at_limit,
    output logic                         wrap
);

    logic [LEVELS-1:0][IDX_W-1:0] r_idx;
    logic [LEVELS-1:0]            w_carry;

    for (genvar gl = 0; gl < LEVELS; gl++) begin : g_level
        assign at_limit[gl] = (r_idx[gl] == limit[gl]);
        if (gl == 0) begin : g_inner
            assign w_carry[gl] = advance;
        end else begin : g_outer
            assign w_carry[gl] = advance & (&at_limit[gl-1:0]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_idx <= '0;
        end else begin
            for (int l = 0; l < LEVELS; l++) begin
                if (w_carry[l]) begin
                    r_idx[l] <= at_limit[l] ? '0 : r_idx[l] + IDX_W'(1);
                end
            end
        end
    end

    assign idx  = r_idx;
    assign wrap = advance & (&at_limit);

endmodule
`default_nettype wire

// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : matmul_sequencer
// Brief    : Walks A/B reads for C = A*B, drives read-aligned MAC control and
//            C writes, then serves host-paced readout of C.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [DIM_W-1:0]   rows_a,
    input  logic [DIM_W-1:0]   inner,
    input  logic [DIM_W-1:0]   cols_b,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               rd_en,
    output logic [IDX_W-1:0]   a_row,
    output logic [IDX_W-1:0]   a_col,
    output logic [IDX_W-1:0]   b_row,
    output logic [IDX_W-1:0]   b_col,
    output logic               mac_clear,
    output logic               mac_en,
    output logic               c_we,
    output logic [IDX_W-1:0]   c_row,
    output logic [IDX_W-1:0]   c_col,
    input  logic               sample_load,
    output logic               rc_en,
    output logic [IDX_W-1:0]   rc_row,
    output logic [IDX_W-1:0]   rc_col,
    output logic               sample,
    output logic [2*DIM_W-1:0] resulting_size
);

    state_t             r_state;
    logic [DIM_W-1:0]   r_m, r_n, r_p;
    logic               r_busy, r_done, r_error, r_rd_en;
    rd_tag_t            r_pipe [RD_LAT];
    logic               r_c_we, r_c_fin;
    logic [IDX_W-1:0]   r_c_row, r_c_col;
    logic [RD_LAT-1:0]  r_smp;

    logic                  w_can_start, w_dims_ok, w_accept, w_reject, w_rc_en;
    logic [2:0][IDX_W-1:0] w_ijk_limit, w_ijk_idx;
    logic [2:0]            w_ijk_at;
    logic                  w_ijk_wrap;
    logic [1:0][IDX_W-1:0] w_rd_limit, w_rd_idx;
    logic [1:0]            w_unused_rd_at;
    logic                  w_unused_rd_wrap;
    rd_tag_t               w_tag, w_tail;

    assign w_can_start = (r_state == IDLE) || (r_state == READOUT);
    assign w_dims_ok   = dim_ok(rows_a) && dim_ok(inner) && dim_ok(cols_b);
    assign w_accept    = start && w_can_start && w_dims_ok;
    assign w_reject    = start && w_can_start && !w_dims_ok;
    // A new job takes priority over a readout request in the same cycle.
    assign w_rc_en     = (r_state == READOUT) && sample_load && !w_accept;

    assign w_ijk_limit[0] = dim_last(r_n);
    assign w_ijk_limit[1] = dim_last(r_p);
    assign w_ijk_limit[2] = dim_last(r_m);
    assign w_rd_limit[0]  = dim_last(r_p);
    assign w_rd_limit[1]  = dim_last(r_m);

    mm_index_counter #(.LEVELS(3)) u_ijk (
        .clock    (clock),
        .reset    (reset),
        .clear    (w_accept),
        .advance  (r_rd_en),
        .limit    (w_ijk_limit),
        .idx      (w_ijk_idx),
        .at_limit (w_ijk_at),
        .wrap     (w_ijk_wrap)
    );

    mm_index_counter #(.LEVELS(2)) u_readout (
        .clock    (clock),
        .reset    (reset),
        .clear    (w_accept),
        .advance  (w_rc_en),
        .limit    (w_rd_limit),
        .idx      (w_rd_idx),
        .at_limit (w_unused_rd_at),
        .wrap     (w_unused_rd_wrap)
    );

    always_comb begin
        w_tag = '0;
        if (r_rd_en) begin
            w_tag.valid    = 1'b1;
            w_tag.clear    = (w_ijk_idx[0] == '0);
            w_tag.acc_last = w_ijk_at[0];
            w_tag.fin      = &w_ijk_at;
            w_tag.row      = w_ijk_idx[2];
            w_tag.col      = w_ijk_idx[1];
        end
    end

    assign w_tail = r_pipe[RD_LAT-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_n     <= '0;
            r_p     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_rd_en <= 1'b0;
            for (int s = 0; s < RD_LAT; s++) r_pipe[s] <= '0;
            r_c_we  <= 1'b0;
            r_c_fin <= 1'b0;
            r_c_row <= '0;
            r_c_col <= '0;
            r_smp   <= '0;
        end else begin
            r_error   <= w_reject;
            r_pipe[0] <= w_tag;
            for (int s = 1; s < RD_LAT; s++) r_pipe[s] <= r_pipe[s-1];
            // C write lands one cycle after the final accumulate of a dot product.
            r_c_we  <= w_tail.valid & w_tail.acc_last;
            r_c_fin <= w_tail.valid & w_tail.acc_last & w_tail.fin;
            r_c_row <= (w_tail.valid & w_tail.acc_last) ? w_tail.row : '0;
            r_c_col <= (w_tail.valid & w_tail.acc_last) ? w_tail.col : '0;
            r_smp[0] <= w_rc_en;
            for (int s = 1; s < RD_LAT; s++) r_smp[s] <= r_smp[s-1];

            case (r_state)
                IDLE, READOUT: begin
                    if (w_accept) begin
                        r_state <= COMPUTE;
                        r_m     <= rows_a;
                        r_n     <= inner;
                        r_p     <= cols_b;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_rd_en <= 1'b1;
                    end
                end
                COMPUTE: begin
                    if (w_ijk_wrap) begin
                        r_state <= DRAIN;
                        r_rd_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (r_c_fin) begin
                        r_state <= READOUT;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign rd_en          = r_rd_en;
    assign a_row          = w_ijk_idx[2];
    assign a_col          = w_ijk_idx[0];
    assign b_row          = w_ijk_idx[0];
    assign b_col          = w_ijk_idx[1];
    assign mac_en         = w_tail.valid;
    assign mac_clear      = w_tail.valid & w_tail.clear;
    assign c_we           = r_c_we;
    assign c_row          = r_c_row;
    assign c_col          = r_c_col;
    assign rc_en          = w_rc_en;
    assign rc_row         = w_rd_idx[1];
    assign rc_col         = w_rd_idx[0];
    assign sample         = r_smp[RD_LAT-1];
    assign resulting_size = {r_m, r_p};

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_sequencer
// Brief    : Self-checking bench; expected waveforms come from the job's
//            cycle arithmetic and a row-major readout model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_sequencer;
    import matmul_pkg::*;

    localparam int RD_LAT = 1;
    localparam int ALL_W  = 9 + 8 * IDX_W + 2 * DIM_W;

    logic               clock = 1'b0;
    logic               reset, start, sample_load;
    logic [DIM_W-1:0]   rows_a, inner, cols_b;
    logic               busy, done, error, rd_en, mac_clear, mac_en, c_we, rc_en, sample;
    logic [IDX_W-1:0]   a_row, a_col, b_row, b_col, c_row, c_col, rc_row, rc_col;
    logic [2*DIM_W-1:0] resulting_size;
    logic [ALL_W-1:0]   all_outs;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit exp_smp [int];
    bit model_done = 1'b0;
    logic [2*DIM_W-1:0] model_size = '0;
    int model_m = 1, model_p = 1, model_rr = 0, model_rc = 0;

    always #5 clock = ~clock;

    matmul_sequencer #(.RD_LAT(RD_LAT)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .rows_a         (rows_a),
        .inner          (inner),
        .cols_b         (cols_b),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .rd_en          (rd_en),
        .a_row          (a_row),
        .a_col          (a_col),
        .b_row          (b_row),
        .b_col          (b_col),
        .mac_clear      (mac_clear),
        .mac_en         (mac_en),
        .c_we           (c_we),
        .c_row          (c_row),
        .c_col          (c_col),
        .sample_load    (sample_load),
        .rc_en          (rc_en),
        .rc_row         (rc_row),
        .rc_col         (rc_col),
        .sample         (sample),
        .resulting_size (resulting_size)
    );

    assign all_outs = {busy, done, error, rd_en, mac_clear, mac_en, c_we, rc_en, sample,
                       a_row, a_col, b_row, b_col, c_row, c_col, rc_row, rc_col, resulting_size};

    // Inputs change just after the rising edge; outputs are read at the falling edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sample_load = 1'b0;
        rows_a = '0; inner = '0; cols_b = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", all_outs);
        end
    endtask

    // Runs one job from acceptance (t=0) until done rises, checking every cycle.
    task automatic run_job(input int m, input int n, input int p,
                           input int inject_at, input bit load_at_start);
        int total, last_t, r;
        logic [8:0] got_c, exp_c;
        bit e_rd, e_mac, e_clr, e_we, e_busy, e_done, e_smp;
        total  = m * n * p;
        last_t = total + RD_LAT + 2;
        for (int t = 0; t <= last_t; t++) begin
            next_cycle();
            start       = (t == 0) || (t == inject_at);
            sample_load = (t == 0) && load_at_start;
            if (t == 0) begin
                rows_a = DIM_W'(m); inner = DIM_W'(n); cols_b = DIM_W'(p);
            end else if (t == inject_at) begin
                rows_a = DIM_W'($urandom_range(0, 40));
                inner  = DIM_W'($urandom_range(0, 40));
                cols_b = DIM_W'($urandom_range(0, 40));
            end
            @(negedge clock);
            e_rd   = (t >= 1) && (t <= total);
            e_mac  = (t - RD_LAT >= 1) && (t - RD_LAT <= total);
            e_clr  = e_mac && (((t - RD_LAT - 1) % n) == 0);
            r      = t - RD_LAT - 2;
            e_we   = (r >= 0) && (r < total) && ((r % n) == n - 1);
            e_busy = (t >= 1) && (t <= total + RD_LAT + 1);
            e_done = (t == 0) ? model_done : (t >= last_t);
            e_smp  = exp_smp.exists(cyc);
            got_c  = {rd_en, mac_en, mac_clear, c_we, busy, done, error, rc_en, sample};
            exp_c  = {e_rd, e_mac, e_clr, e_we, e_busy, e_done, 1'b0, 1'b0, e_smp};
            checks++;
            if (got_c !== exp_c) begin
                errors++;
                $display("FAIL job_ctrl %0dx%0dx%0d t=%0d got=%b exp=%b (rd,mac,clr,we,busy,done,err,rc,smp)",
                         m, n, p, t, got_c, exp_c);
            end
            if (e_rd) begin
                r = t - 1;
                checks++;
                if ({a_row, a_col, b_row, b_col} !== {IDX_W'(r / (n * p)), IDX_W'(r % n),
                                                     IDX_W'(r % n), IDX_W'((r / n) % p)}) begin
                    errors++;
                    $display("FAIL rd_index %0dx%0dx%0d t=%0d got a=(%0d,%0d) b=(%0d,%0d) exp read #%0d",
                             m, n, p, t, a_row, a_col, b_row, b_col, r);
                end
            end
            if (e_we) begin
                r = t - RD_LAT - 2;
                checks++;
                if ({c_row, c_col} !== {IDX_W'(r / (n * p)), IDX_W'((r / n) % p)}) begin
                    errors++;
                    $display("FAIL c_index %0dx%0dx%0d t=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                             m, n, p, t, c_row, c_col, r / (n * p), (r / n) % p);
                end
            end
            if (t == 1) begin
                checks++;
                if (resulting_size !== {DIM_W'(m), DIM_W'(p)}) begin
                    errors++;
                    $display("FAIL resulting_size got=%h exp=%h", resulting_size, {DIM_W'(m), DIM_W'(p)});
                end
            end
        end
        start = 1'b0;
        sample_load = 1'b0;
        model_done = 1'b1;
        model_size = {DIM_W'(m), DIM_W'(p)};
        model_m = m; model_p = p; model_rr = 0; model_rc = 0;
    endtask

    task automatic test_readout(input int ncyc, input bit force_all);
        bit sl, es;
        for (int t = 0; t < ncyc + RD_LAT; t++) begin
            next_cycle();
            start = 1'b0;
            sl = (t < ncyc) && (force_all || ($urandom_range(0, 1) == 1));
            sample_load = sl;
            @(negedge clock);
            es = exp_smp.exists(cyc);
            checks++;
            if ({rc_en, sample, done, busy} !== {sl, es, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL readout_ctrl t=%0d got=%b exp=%b (rc_en,sample,done,busy)",
                         t, {rc_en, sample, done, busy}, {sl, es, 1'b1, 1'b0});
            end
            if (sl) begin
                checks++;
                if ({rc_row, rc_col} !== {IDX_W'(model_rr), IDX_W'(model_rc)}) begin
                    errors++;
                    $display("FAIL readout_index t=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                             t, rc_row, rc_col, model_rr, model_rc);
                end
                exp_smp[cyc + RD_LAT] = 1'b1;
                model_rc++;
                if (model_rc == model_p) begin
                    model_rc = 0;
                    model_rr = (model_rr + 1 == model_m) ? 0 : model_rr + 1;
                end
            end
        end
        sample_load = 1'b0;
    endtask

    task automatic test_illegal();
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            start  = 1'b1;
            rows_a = (c == 2) ? DIM_W'(0)  : DIM_W'(2);
            inner  = (c == 0) ? DIM_W'(0)  : DIM_W'(2);
            cols_b = (c == 1) ? DIM_W'(33) : DIM_W'(2);
            next_cycle();
            start = 1'b0;
            @(negedge clock);
            checks++;
            if ({error, busy} !== 2'b10 || resulting_size !== model_size) begin
                errors++;
                $display("FAIL illegal_pulse case=%0d got err=%b busy=%b size=%h exp err=1 busy=0 size=%h",
                         c, error, busy, resulting_size, model_size);
            end
            next_cycle();
            @(negedge clock);
            checks++;
            if ({error, busy} !== 2'b00) begin
                errors++;
                $display("FAIL illegal_after case=%0d got err=%b busy=%b exp 0 0", c, error, busy);
            end
        end
    endtask

    task automatic test_start_over_sample();
        next_cycle();
        start = 1'b0;
        sample_load = 1'b1;
        @(negedge clock);
        checks++;
        if ({rc_en, rc_row, rc_col} !== {1'b1, IDX_W'(model_rr), IDX_W'(model_rc)}) begin
            errors++;
            $display("FAIL pre_start_sample got en=%b (%0d,%0d) exp en=1 (%0d,%0d)",
                     rc_en, rc_row, rc_col, model_rr, model_rc);
        end
        exp_smp[cyc + RD_LAT] = 1'b1;
        run_job(2, 2, 2, -1, 1'b1);
    endtask

    task automatic test_busy_reset();
        run_job(3, 3, 3, 5, 1'b0);
        next_cycle();
        start = 1'b1; rows_a = DIM_W'(4); inner = DIM_W'(4); cols_b = DIM_W'(4);
        for (int t = 0; t < 10; t++) begin
            next_cycle();
            start = 1'b0;
        end
        @(negedge clock);
        checks++;
        if (rd_en !== 1'b1) begin
            errors++;
            $display("FAIL midjob_rd_en got=%b exp=1", rd_en);
        end
        next_cycle();
        reset = 1'b1;
        exp_smp.delete();
        model_done = 1'b0;
        model_size = '0;
        for (int t = 0; t < RD_LAT + 5; t++) begin
            next_cycle();
            reset = 1'b0;
            @(negedge clock);
            checks++;
            if (all_outs !== '0) begin
                errors++;
                $display("FAIL post_reset t=%0d got=%h exp=0", t, all_outs);
            end
        end
        run_job(2, 2, 3, -1, 1'b0);
    endtask

    task automatic test_random_jobs();
        int m, n, p, inj;
        for (int j = 0; j < 6; j++) begin
            m = $urandom_range(1, 5);
            n = $urandom_range(1, 5);
            p = $urandom_range(1, 5);
            inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, m * n * p + RD_LAT + 1) : -1;
            run_job(m, n, p, inj, 1'b0);
            test_readout($urandom_range(4, 20), 1'b0);
        end
    endtask

    task automatic test_boundary();
        run_job(3, 1, 4, -1, 1'b0);
        test_readout(14, 1'b1);
        run_job(32, 2, 32, 100, 1'b0);
        test_readout(40, 1'b0);
    endtask

    initial begin
        test_reset();
        test_illegal();
        run_job(1, 1, 1, -1, 1'b0);
        run_job(2, 3, 2, -1, 1'b0);
        test_readout(5, 1'b1);
        test_illegal();
        test_readout(10, 1'b0);
        test_start_over_sample();
        test_readout(6, 1'b1);
        test_busy_reset();
        test_random_jobs();
        test_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
